// File: rtl/fp_pkg.sv
// Shared floating-point types: operand formats, rounding modes, unrounded results
// and the divide/sqrt arbiter state encoding.
package fp_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  typedef enum logic {
    DIV  = 1'b0,
    SQRT = 1'b1
  } divsqrt_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Wide enough to carry an FP64 mantissa plus guard/sticky before rounding.
  typedef struct packed {
    logic               sign;
    logic signed [12:0] exponent;
    logic [53:0]        mantissa;
    logic               guard;
    logic               sticky;
  } uround_res_t;

  function automatic int fp_width(input fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      BF16:    return 16;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/fp_divsqrt_arb.sv
// Two-requester arbiter in front of one shared iterative divide/sqrt unit; FP_ARB_RR_EN selects round-robin grant.
// Latency: accept at cycle 0, unit start at cycle 1, response one cycle after the unit's done pulse.
// Backpressure: a single transaction in flight; no request is accepted until the response handshakes.
module fp_divsqrt_arb
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int FP_WIDTH = fp_width(FP_FORMAT)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [1:0]               req_op_i,
  input  logic [1:0][FP_WIDTH-1:0] req_a_i,
  input  logic [1:0][FP_WIDTH-1:0] req_b_i,
  input  roundmode_e [1:0]         req_rnd_i,
  output logic                     unit_start_o,
  output logic                     unit_op_o,
  output logic [FP_WIDTH-1:0]      unit_a_o,
  output logic [FP_WIDTH-1:0]      unit_b_o,
  output roundmode_e               unit_rnd_o,
  input  logic                     unit_done_i,
  input  uround_res_t              unit_result_i,
  input  logic                     unit_dz_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_id_o,
  output uround_res_t              rsp_result_o,
  output logic                     rsp_dz_o,
  output logic                     busy_o
);

  arb_state_e state_q;
  logic       any_req;
  logic       accept;
  logic       grant_id;

  assign any_req     = |req_valid_i;
  assign accept      = (state_q == ARB_IDLE) && any_req && !reset_i;
  assign req_ready_o = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

`ifdef FP_ARB_RR_EN
  logic last_id_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_id = ~req_valid_i[0];
    if (req_valid_i == 2'b11) grant_id = ~last_id_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_id_q <= 1'b1;
    end else if (accept) begin
      last_id_q <= grant_id;
    end
  end
`else
  assign grant_id = ~req_valid_i[0];
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ARB_IDLE;
      unit_start_o <= 1'b0;
      unit_op_o    <= 1'b0;
      unit_a_o     <= '0;
      unit_b_o     <= '0;
      unit_rnd_o   <= RNE;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_result_o <= '0;
      rsp_dz_o     <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            unit_op_o    <= req_op_i[grant_id];
            unit_a_o     <= req_a_i[grant_id];
            unit_b_o     <= req_b_i[grant_id];
            unit_rnd_o   <= req_rnd_i[grant_id];
            rsp_id_o     <= grant_id;
            unit_start_o <= 1'b1;
            busy_o       <= 1'b1;
            state_q      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          unit_start_o <= 1'b0;
          state_q      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // Unit operands stay frozen here; a done pulse in any other state is stale.
          if (unit_done_i) begin
            rsp_result_o <= unit_result_i;
            rsp_dz_o     <= unit_dz_i;
            rsp_valid_o  <= 1'b1;
            state_q      <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state_q     <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divsqrt_arb.sv
// Bench for fp_divsqrt_arb: directed scenarios plus a randomized transaction-level scoreboard.
module tb_fp_divsqrt_arb;
  import fp_pkg::*;

  localparam int W = fp_width(FP32);

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic [1:0]           req_valid_i, req_ready_o, req_op_i;
  logic [1:0][W-1:0]    req_a_i, req_b_i;
  roundmode_e [1:0]     req_rnd_i;
  logic                 unit_start_o, unit_op_o;
  logic [W-1:0]         unit_a_o, unit_b_o;
  roundmode_e           unit_rnd_o;
  logic                 unit_done_i;
  uround_res_t          unit_result_i;
  logic                 unit_dz_i;
  logic                 rsp_valid_o, rsp_ready_i, rsp_id_o;
  uround_res_t          rsp_result_o;
  logic                 rsp_dz_o, busy_o;

  int checks = 0;
  int failures = 0;

  // Inputs for the next cycle, applied just after the rising edge.
  logic                 nxt_rst, nxt_rdy, nxt_stray;
  logic [1:0]           nxt_valid, nxt_op;
  logic [1:0][W-1:0]    nxt_a, nxt_b;
  roundmode_e [1:0]     nxt_rnd;

  // Unit model: done pulses unit_lat cycles after the start pulse.
  int          cd = -1;
  int          unit_lat = 10;
  uround_res_t unit_val;
  logic        unit_dz_val = 1'b0;
  int          cyc = 0;
  int          m_last = 1;

  always #5 clk = ~clk;

  fp_divsqrt_arb #(.FP_FORMAT(FP32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rnd_i(req_rnd_i),
    .unit_start_o(unit_start_o), .unit_op_o(unit_op_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o), .unit_rnd_o(unit_rnd_o),
    .unit_done_i(unit_done_i), .unit_result_i(unit_result_i), .unit_dz_i(unit_dz_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_dz_o(rsp_dz_o), .busy_o(busy_o)
  );

  function automatic uround_res_t rand_res();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[$bits(uround_res_t)-1:0];
  endfunction

  function automatic int pick(input logic [1:0] v);
`ifdef FP_ARB_RR_EN
    if (v == 2'b11) return (m_last == 1) ? 0 : 1;
`endif
    return v[0] ? 0 : 1;
  endfunction

  function automatic logic [1:0] onehot(input int id);
    return (id == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic rand_ops();
    nxt_op = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      nxt_a[i]   = $urandom;
      nxt_b[i]   = $urandom;
      nxt_rnd[i] = roundmode_e'($urandom_range(0, 4));
    end
  endtask

  // One clock: drive after the rising edge, return at the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    reset_i       = nxt_rst;
    req_valid_i   = nxt_valid;
    req_op_i      = nxt_op;
    req_a_i       = nxt_a;
    req_b_i       = nxt_b;
    req_rnd_i     = nxt_rnd;
    rsp_ready_i   = nxt_rdy;
    unit_done_i   = nxt_stray;
    unit_result_i = ~unit_val;
    unit_dz_i     = 1'b0;
    if (nxt_rst) cd = -1;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        unit_done_i   = 1'b1;
        unit_result_i = unit_val;
        unit_dz_i     = unit_dz_val;
        cd            = -1;
      end
    end
    @(negedge clk);
    if (unit_start_o === 1'b1) cd = unit_lat;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      ok = (rsp_valid_o === 1'b1);
    end
  endtask

  task automatic test_reset();
    nxt_rst = 1'b1; nxt_valid = 2'b11; nxt_rdy = 1'b1;
    step();
    m_last = 1;
    checks++;
    if (req_ready_o !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", req_ready_o);
    end
    checks++;
    if ({unit_start_o, unit_op_o, rsp_valid_o, rsp_id_o, rsp_dz_o, busy_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {unit_start_o, unit_op_o, rsp_valid_o, rsp_id_o, rsp_dz_o, busy_o});
    end
    checks++;
    if (unit_a_o !== '0 || unit_b_o !== '0 || unit_rnd_o !== RNE) begin
      failures++; $display("FAIL reset_unit_ops got a=%h b=%h rnd=%0d exp 0", unit_a_o, unit_b_o, unit_rnd_o);
    end
    checks++;
    if (rsp_result_o !== '0) begin
      failures++; $display("FAIL reset_result got=%h exp=0", rsp_result_o);
    end
    nxt_rst = 1'b0; nxt_valid = 2'b00; nxt_rdy = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_release got busy=%b rsp_valid=%b exp 0 0", busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_single();
    int c0;
    bit ok;
    rand_ops();
    nxt_op = 2'b00; nxt_a[0] = 32'h40400000; nxt_b[0] = 32'h3F800000; nxt_rnd[0] = RTZ;
    unit_lat = 10; unit_val = rand_res(); unit_dz_val = 1'b0;
    nxt_valid = 2'b01;
    step();
    c0 = cyc;
    checks++;
    if (req_ready_o !== 2'b01) begin
      failures++; $display("FAIL single_accept got=%b exp=01", req_ready_o);
    end
    m_last = 0;
    nxt_valid = 2'b00;
    step();
    checks++;
    if (unit_start_o !== 1'b1 || unit_op_o !== 1'b0 || unit_a_o !== 32'h40400000 ||
        unit_b_o !== 32'h3F800000 || unit_rnd_o !== RTZ || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_issue got start=%b op=%b a=%h b=%h rnd=%0d busy=%b exp 1 0 40400000 3f800000 1 1",
               unit_start_o, unit_op_o, unit_a_o, unit_b_o, unit_rnd_o, busy_o);
    end
    wait_rsp(30, ok);
    checks++;
    if (!ok || cyc - c0 != 12) begin
      failures++; $display("FAIL single_latency got valid=%0d at cycle %0d exp cycle 12", ok, cyc - c0);
    end
    checks++;
    if (rsp_id_o !== 1'b0 || rsp_result_o !== unit_val || rsp_dz_o !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got id=%b res=%h dz=%b exp id=0 res=%h dz=0", rsp_id_o, rsp_result_o, rsp_dz_o, unit_val);
    end
    nxt_rdy = 1'b1;
    step();
    nxt_rdy = 1'b0;
    step();
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL single_idle got rsp_valid=%b busy=%b exp 0 0", rsp_valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int  k, exp_id;
    bit  got, ok;
    nxt_rst = 1'b1; step(); m_last = 1; nxt_rst = 1'b0;
    rand_ops(); nxt_valid = 2'b11; nxt_rdy = 1'b1; unit_lat = 3;
    for (int i = 0; i < 4; i++) begin
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
        step(); k++;
        got = (req_ready_o !== 2'b00);
      end
      exp_id = pick(2'b11);
      checks++;
      if (!got || req_ready_o !== onehot(exp_id) || (i > 0 && k != 1)) begin
        failures++;
        $display("FAIL b2b_grant txn=%0d got=%b after %0d cycles exp=%b after 1", i, req_ready_o, k, onehot(exp_id));
      end
      m_last = exp_id;
      unit_val = rand_res(); unit_dz_val = 1'b0;
      wait_rsp(20, ok);
      checks++;
      if (!ok || rsp_id_o !== 1'(exp_id) || rsp_result_o !== unit_val || req_ready_o !== 2'b00) begin
        failures++;
        $display("FAIL b2b_rsp txn=%0d got valid=%0d id=%b ready=%b exp valid=1 id=%0d ready=00",
                 i, ok, rsp_id_o, req_ready_o, exp_id);
      end
    end
    nxt_valid = 2'b00; nxt_rdy = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin
      failures++; $display("FAIL b2b_drain got busy=%b rsp_valid=%b exp 0 0", busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rand_ops(); nxt_valid = 2'b10; unit_lat = 2;
    unit_val = rand_res(); unit_dz_val = 1'($urandom_range(0, 1));
    step();
    checks++;
    if (req_ready_o !== 2'b10) begin
      failures++; $display("FAIL bp_accept got=%b exp=10", req_ready_o);
    end
    m_last = 1;
    nxt_valid = 2'b00;
    wait_rsp(10, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_rsp got rsp_valid=0 exp=1 within 10 cycles");
    end
    nxt_valid = 2'b11; nxt_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_result_o !== unit_val ||
          rsp_dz_o !== unit_dz_val || req_ready_o !== 2'b00 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b id=%b dz=%b ready=%b exp 1 1 %b 00",
                 i, rsp_valid_o, rsp_id_o, rsp_dz_o, req_ready_o, unit_dz_val);
      end
    end
    nxt_valid = 2'b00; nxt_rdy = 1'b1;
    step();
    nxt_rdy = 1'b0;
    step();
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL bp_release got rsp_valid=%b busy=%b exp 0 0", rsp_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_in_wait();
    rand_ops(); nxt_valid = 2'b01; unit_lat = 50; unit_val = rand_res();
    step();
    m_last = 0;
    nxt_valid = 2'b00;
    step(); step(); step();
    nxt_rst = 1'b1;
    step();
    m_last = 1;
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || unit_start_o !== 1'b0) begin
      failures++; $display("FAIL abort_reset got busy=%b rsp_valid=%b start=%b exp 0 0 0", busy_o, rsp_valid_o, unit_start_o);
    end
    nxt_rst = 1'b0; nxt_stray = 1'b1;
    step();
    nxt_stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || unit_start_o !== 1'b0) begin
        failures++;
        $display("FAIL abort_stray cycle=%0d got busy=%b rsp_valid=%b start=%b exp 0 0 0",
                 i, busy_o, rsp_valid_o, unit_start_o);
      end
    end
  endtask

  task automatic test_sqrt();
    bit ok;
    rand_ops();
    nxt_op[0] = 1'b1; nxt_a[0] = 32'h40800000; nxt_b[0] = 32'hFFFFFFFF;
    unit_lat = 4; unit_val = rand_res(); unit_dz_val = 1'b0;
    nxt_valid = 2'b01;
    step();
    m_last = 0;
    nxt_valid = 2'b00;
    step();
    checks++;
    if (unit_start_o !== 1'b1 || unit_op_o !== 1'b1 || unit_a_o !== 32'h40800000) begin
      failures++;
      $display("FAIL sqrt_issue got start=%b op=%b a=%h exp 1 1 40800000", unit_start_o, unit_op_o, unit_a_o);
    end
    wait_rsp(15, ok);
    checks++;
    if (!ok || rsp_result_o !== unit_val || rsp_id_o !== 1'b0) begin
      failures++; $display("FAIL sqrt_rsp got valid=%0d res=%h id=%b exp 1 %h 0", ok, rsp_result_o, rsp_id_o, unit_val);
    end
    nxt_rdy = 1'b1; step(); nxt_rdy = 1'b0; step();
  endtask

  task automatic test_div_by_zero();
    bit ok;
    rand_ops();
    nxt_op[1] = 1'b0; nxt_b[1] = 32'h00000000;
    unit_lat = 5; unit_val = rand_res(); unit_dz_val = 1'b1;
    nxt_valid = 2'b10;
    step();
    m_last = 1;
    nxt_valid = 2'b00;
    wait_rsp(15, ok);
    checks++;
    if (!ok || rsp_dz_o !== 1'b1 || rsp_id_o !== 1'b1) begin
      failures++; $display("FAIL dz_rsp got valid=%0d dz=%b id=%b exp 1 1 1", ok, rsp_dz_o, rsp_id_o);
    end
    nxt_rdy = 1'b1; step(); nxt_rdy = 1'b0; step();
    unit_dz_val = 1'b0;
  endtask

  // Scoreboard: at most one outstanding transaction, checked against its recorded request.
  task automatic test_random();
    logic        outstanding = 1'b0;
    logic        start_due = 1'b0;
    logic        rsp_exp = 1'b0;
    int          done_cnt = 0;
    int          n = 0;
    int          id;
    logic [1:0]  exp_rdy;
    logic        r_id, r_op, r_dz;
    logic [W-1:0] r_a, r_b;
    roundmode_e  r_rnd;
    uround_res_t r_res;
    while (done_cnt < 40 && n < 4000) begin
      rand_ops();
      nxt_valid = 2'($urandom_range(0, 3));
      nxt_rdy   = 1'($urandom_range(0, 1));
      step(); n++;
      exp_rdy = 2'b00; id = 0;
      if (!outstanding && req_valid_i != 2'b00) begin
        id = pick(req_valid_i);
        exp_rdy = onehot(id);
      end
      checks++;
      if (req_ready_o !== exp_rdy || busy_o !== outstanding) begin
        failures++;
        $display("FAIL rnd_grant cyc=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                 cyc, req_ready_o, busy_o, exp_rdy, outstanding);
      end
      checks++;
      if (unit_start_o !== start_due ||
          (outstanding && (unit_op_o !== r_op || unit_a_o !== r_a || unit_b_o !== r_b || unit_rnd_o !== r_rnd))) begin
        failures++;
        $display("FAIL rnd_unit cyc=%0d got start=%b op=%b a=%h b=%h exp start=%b op=%b a=%h b=%h",
                 cyc, unit_start_o, unit_op_o, unit_a_o, unit_b_o, start_due, r_op, r_a, r_b);
      end
      checks++;
      if (rsp_valid_o !== rsp_exp ||
          (rsp_exp && (rsp_id_o !== r_id || rsp_result_o !== r_res || rsp_dz_o !== r_dz))) begin
        failures++;
        $display("FAIL rnd_rsp cyc=%0d got valid=%b id=%b dz=%b exp valid=%b id=%b dz=%b",
                 cyc, rsp_valid_o, rsp_id_o, rsp_dz_o, rsp_exp, r_id, r_dz);
      end
      start_due = 1'b0;
      if (rsp_exp && rsp_ready_i) begin
        rsp_exp = 1'b0; outstanding = 1'b0; done_cnt++;
      end
      if (unit_done_i) rsp_exp = 1'b1;
      if (exp_rdy != 2'b00) begin
        outstanding = 1'b1; start_due = 1'b1;
        r_id = 1'(id); r_op = req_op_i[id]; r_a = req_a_i[id]; r_b = req_b_i[id]; r_rnd = req_rnd_i[id];
        m_last = id;
        unit_lat = $urandom_range(1, 6);
        unit_val = rand_res(); unit_dz_val = 1'($urandom_range(0, 1));
        r_res = unit_val; r_dz = unit_dz_val;
      end
    end
    checks++;
    if (done_cnt != 40) begin
      failures++; $display("FAIL rnd_progress got %0d responses exp 40", done_cnt);
    end
    nxt_valid = 2'b00; nxt_rdy = 1'b1;
    for (int i = 0; i < 50 && busy_o !== 1'b0; i++) step();
    nxt_rdy = 1'b0;
    step();
  endtask

  initial begin
    reset_i = 1'b1; req_valid_i = 2'b00; req_op_i = 2'b00; req_a_i = '0; req_b_i = '0;
    req_rnd_i[0] = RNE; req_rnd_i[1] = RNE;
    rsp_ready_i = 1'b0; unit_done_i = 1'b0; unit_result_i = '0; unit_dz_i = 1'b0;
    unit_val = '0;
    nxt_rst = 1'b1; nxt_rdy = 1'b0; nxt_stray = 1'b0; nxt_valid = 2'b00; nxt_op = 2'b00;
    nxt_a = '0; nxt_b = '0; nxt_rnd[0] = RNE; nxt_rnd[1] = RNE;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wait();
    test_sqrt();
    test_div_by_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
